// File: rtl/program_memory_loader_pkg.sv
// Shared types and sizing for the boot-time program store and its loader.
package program_loader_pkg;

  localparam int DEPTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte-stream load channel plus the core memory port, bundled for the loader.
interface program_memory_loader_if;
  import program_loader_pkg::*;

  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_last;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  halted;
  logic                  start_execution;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport slave (
    input  load_valid, load_byte, load_last, mem_addr, mem_write_data, mem_write, halted,
    output load_ready, mem_read_data, start_execution, load_error, words_loaded
  );

  modport master (
    output load_valid, load_byte, load_last, mem_addr, mem_write_data, mem_write, halted,
    input  load_ready, mem_read_data, start_execution, load_error, words_loaded
  );
endinterface

// File: rtl/program_memory_loader_ram.sv
// 32 x 16 register-array memory: one synchronous write port, one async read port.
module program_ram
  import program_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_memory_loader.sv
// Boot loader: packs a big-endian byte stream into program memory, then hands
// the memory port to the core until it halts.
//
// state | meaning
// LOAD  | accepting bytes, core writes ignored
// RUN   | core owns the write port, start_execution high
// DONE  | core halted, memory frozen until reset
// ERROR | odd byte count or overflow, sticky until reset
module program_memory_loader
  import program_loader_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  program_memory_loader_if.slave   bus
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_phase;
  logic                  w_phase_nxt;
  logic [7:0]            r_hold;
  logic [7:0]            w_hold_nxt;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic [ADDR_WIDTH:0]   w_words_nxt;
  logic                  w_accept;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= LOAD;
      r_phase        <= 1'b0;
      r_hold         <= '0;
      r_words_loaded <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_hold         <= w_hold_nxt;
      r_words_loaded <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold;
    w_words_nxt = r_words_loaded;
    w_accept    = (r_state == LOAD) && bus.load_valid;
    w_we        = 1'b0;
    w_waddr     = bus.mem_addr;
    w_wdata     = bus.mem_write_data;

    case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (r_words_loaded == (ADDR_WIDTH+1)'(DEPTH)) begin
            w_state_nxt = ERROR;
          end else if (!r_phase) begin
            // A final byte arriving on an even boundary leaves half a word.
            if (bus.load_last) begin
              w_state_nxt = ERROR;
            end else begin
              w_hold_nxt  = bus.load_byte;
              w_phase_nxt = 1'b1;
            end
          end else begin
            w_we        = 1'b1;
            w_waddr     = r_words_loaded[ADDR_WIDTH-1:0];
            w_wdata     = {r_hold, bus.load_byte};
            w_words_nxt = r_words_loaded + 1'b1;
            w_phase_nxt = 1'b0;
            if (bus.load_last) w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        w_we = bus.mem_write;
        if (bus.halted) w_state_nxt = DONE;
      end
      default: ;
    endcase
  end

  program_ram u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (bus.mem_addr),
    .o_rdata (bus.mem_read_data)
  );

  assign bus.load_ready      = (r_state == LOAD);
  assign bus.start_execution = (r_state == RUN);
  assign bus.load_error      = (r_state == ERROR);
  assign bus.words_loaded    = r_words_loaded;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: vector table plus multi-cycle sequences.
module tb_program_memory_loader;
  import program_loader_pkg::*;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  program_memory_loader_if bus ();

  program_memory_loader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  b;
    logic        last;
    logic [4:0]  a;
    logic [15:0] wd;
    logic        wr;
    logic        h;
    logic        e_rdy;
    logic        e_start;
    logic        e_err;
    logic [5:0]  e_words;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset              = 1'b0;
    bus.load_valid     = 1'b0;
    bus.load_byte      = 8'h00;
    bus.load_last      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.halted         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic read_mem(input logic [4:0] a, output logic [15:0] d);
    bus.mem_addr = a;
    #1;
    d = bus.mem_read_data;
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  seq6 [6];
    total = 0;
    bad   = 0;
    idle_inputs();

    //             rst v  b      last a  wd        wr h  rdy st err words rdata
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};
    vecs[1]  = '{1'b0,1'b1,8'h0A,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};
    vecs[2]  = '{1'b0,1'b1,8'h05,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd1,16'h0A05};
    vecs[3]  = '{1'b0,1'b1,8'h00,1'b0,5'd1,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd1,16'h0000};
    vecs[4]  = '{1'b0,1'b1,8'h00,1'b1,5'd1,16'h0000,1'b0,1'b0, 1'b0,1'b1,1'b0,6'd2,16'h0000};
    vecs[5]  = '{1'b0,1'b0,8'h00,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b0,1'b1,1'b0,6'd2,16'h0A05};
    vecs[6]  = '{1'b0,1'b0,8'h00,1'b0,5'd5,16'hBEEF,1'b1,1'b0, 1'b0,1'b1,1'b0,6'd2,16'hBEEF};
    vecs[7]  = '{1'b0,1'b0,8'h00,1'b0,5'd7,16'h1234,1'b1,1'b1, 1'b0,1'b0,1'b0,6'd2,16'h1234};
    vecs[8]  = '{1'b0,1'b0,8'h00,1'b0,5'd7,16'h5555,1'b1,1'b0, 1'b0,1'b0,1'b0,6'd2,16'h1234};
    vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,5'd5,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b0,6'd2,16'hBEEF};
    vecs[10] = '{1'b1,1'b0,8'h00,1'b0,5'd5,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};
    vecs[11] = '{1'b0,1'b0,8'h00,1'b0,5'd5,16'hBEEF,1'b1,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};
    vecs[12] = '{1'b0,1'b1,8'h12,1'b0,5'd5,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};
    vecs[13] = '{1'b0,1'b1,8'h34,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd1,16'h1234};
    vecs[14] = '{1'b0,1'b1,8'h56,1'b1,5'd0,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b1,6'd1,16'h1234};
    vecs[15] = '{1'b0,1'b1,8'h78,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b1,6'd1,16'h1234};
    vecs[16] = '{1'b1,1'b0,8'h00,1'b0,5'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b0,6'd0,16'h0000};

    for (int i = 0; i < 17; i++) begin
      reset              = vecs[i].rst;
      bus.load_valid     = vecs[i].v;
      bus.load_byte      = vecs[i].b;
      bus.load_last      = vecs[i].last;
      bus.mem_addr       = vecs[i].a;
      bus.mem_write_data = vecs[i].wd;
      bus.mem_write      = vecs[i].wr;
      bus.halted         = vecs[i].h;
      tick();
      chk($sformatf("vec%0d load_ready", i), 32'(bus.load_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d start_execution", i), 32'(bus.start_execution), 32'(vecs[i].e_start));
      chk($sformatf("vec%0d load_error", i), 32'(bus.load_error), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d words_loaded", i), 32'(bus.words_loaded), 32'(vecs[i].e_words));
      chk($sformatf("vec%0d mem_read_data", i), 32'(bus.mem_read_data), 32'(vecs[i].e_rdata));
    end
    idle_inputs();

    // Full 64-byte program ending exactly at capacity.
    do_reset();
    for (int i = 0; i < 64; i++) send(8'(i), i == 63);
    chk("full start_execution", 32'(bus.start_execution), 32'd1);
    chk("full words_loaded", 32'(bus.words_loaded), 32'd32);
    read_mem(5'd0, d);
    chk("full mem0", 32'(d), 32'h0001);
    read_mem(5'd31, d);
    chk("full mem31", 32'(d), 32'h3E3F);

    // Overflow: 64 bytes without last, then one extra byte.
    do_reset();
    for (int i = 0; i < 64; i++) send(8'(i) ^ 8'h5A, 1'b0);
    chk("ovf words_loaded", 32'(bus.words_loaded), 32'd32);
    chk("ovf ready before extra", 32'(bus.load_ready), 32'd1);
    send(8'hFF, 1'b0);
    chk("ovf load_error", 32'(bus.load_error), 32'd1);
    chk("ovf load_ready", 32'(bus.load_ready), 32'd0);
    chk("ovf start_execution", 32'(bus.start_execution), 32'd0);
    read_mem(5'd31, d);
    chk("ovf mem31", 32'(d), 32'({8'(62) ^ 8'h5A, 8'(63) ^ 8'h5A}));

    // Six bytes with random idle gaps between them.
    do_reset();
    seq6[0] = 8'h11; seq6[1] = 8'h22; seq6[2] = 8'h33;
    seq6[3] = 8'h44; seq6[4] = 8'h55; seq6[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      send(seq6[i], i == 5);
      if (i < 5) begin
        repeat ($urandom_range(0, 4)) tick();
        chk($sformatf("gap%0d words_loaded", i), 32'(bus.words_loaded), 32'((i + 1) / 2));
        chk($sformatf("gap%0d load_ready", i), 32'(bus.load_ready), 32'd1);
      end
    end
    chk("gap start_execution", 32'(bus.start_execution), 32'd1);
    chk("gap words_loaded", 32'(bus.words_loaded), 32'd3);
    read_mem(5'd0, d);
    chk("gap mem0", 32'(d), 32'h1122);
    read_mem(5'd1, d);
    chk("gap mem1", 32'(d), 32'h3344);
    read_mem(5'd2, d);
    chk("gap mem2", 32'(d), 32'h5566);

    // Reset three bytes into a second load, with a byte presented alongside reset.
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    reset          = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'hDD;
    tick();
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    chk("rst words_loaded", 32'(bus.words_loaded), 32'd0);
    chk("rst load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst load_error", 32'(bus.load_error), 32'd0);
    begin
      int nz;
      nz = 0;
      for (int a = 0; a < DEPTH; a++) begin
        read_mem(5'(a), d);
        if (d != 16'h0000) nz++;
      end
      chk("rst nonzero words", 32'(nz), 32'd0);
    end
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    read_mem(5'd0, d);
    chk("fresh mem0", 32'(d), 32'h1234);
    chk("fresh start_execution", 32'(bus.start_execution), 32'd1);
    chk("fresh words_loaded", 32'(bus.words_loaded), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
